// File: rtl/keys_poll_ctrl_if.sv
// rtl/keys_poll_ctrl_if.sv - Avalon-MM style register bus used for both the PIO and host sides
interface keys_poll_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/keys_poll_ctrl.sv
// rtl/keys_poll_ctrl.sv - key PIO poller with debounce, change-event FIFO and host registers
module keys_poll_ctrl #(
  parameter int WIDTH      = 8,
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  keys_poll_ctrl_if.master m,
  keys_poll_ctrl_if.slave  s,
  output logic            irq
);

  localparam int DIV_W = $clog2(POLL_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = 2 * WIDTH;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(POLL_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, UPDATE} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic               read_q;
  logic [WIDTH-1:0]   sample;
  logic [WIDTH-1:0]   last_sample;
  logic [WIDTH-1:0]   debounced;
  logic [CNT_W-1:0]   stable_cnt;
  logic               ctrl_en;
  logic               ctrl_irq_en;
  logic [31:0]        readdata_q;
  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               overflow;

  logic [CNT_W-1:0]   cnt_next;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic [EW-1:0]      head;
  logic               unused_bits;

  assign m.address   = 2'b00;
  assign m.read      = read_q;
  assign m.write     = 1'b0;
  assign m.writedata = 32'h0;
  assign s.readdata  = readdata_q;
  assign unused_bits = ^{m.readdata[31:WIDTH], s.writedata[31:2]};

  always_comb begin
    cnt_next = '0;
    if (sample == last_sample)
      cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
  end

  assign accept  = (cnt_next == CNT_MAX);
  assign push    = (state == UPDATE) && accept && (sample != debounced);
  assign pop     = s.read && (s.address == 2'd1) && (count != '0);
  assign full    = (count == FULL_CNT);
  // A pop frees the slot in the same edge, so a push onto a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      div         <= '0;
      read_q      <= 1'b0;
      sample      <= '0;
      last_sample <= '0;
      debounced   <= '0;
      stable_cnt  <= '0;
    end else begin
      if (!ctrl_en || div == DIV_MAX)
        div <= '0;
      else
        div <= div + DIV_W'(1);

      case (state)
        IDLE: begin
          if (ctrl_en && div == DIV_MAX) begin
            state  <= READ;
            read_q <= 1'b1;
          end
        end
        READ: begin
          read_q <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          sample <= m.readdata[WIDTH-1:0];
          state  <= UPDATE;
        end
        UPDATE: begin
          stable_cnt  <= cnt_next;
          last_sample <= sample;
          if (accept)
            debounced <= sample;
          state <= IDLE;
        end
        default: begin
          read_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {sample ^ debounced, sample};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)
        count <= count + CW'(1);
      else if (!push_ok && pop)
        count <= count - CW'(1);
      // Setting wins over a simultaneous write-one-to-clear.
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (s.write && s.address == 2'd3 && s.writedata[0])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      readdata_q  <= '0;
      irq         <= 1'b0;
    end else begin
      if (s.write && s.address == 2'd2) begin
        ctrl_en     <= s.writedata[0];
        ctrl_irq_en <= s.writedata[1];
      end
      if (s.read) begin
        case (s.address)
          2'd0: readdata_q <= {24'h0, 8'(debounced)};
          2'd1: readdata_q <= (count != '0) ?
                  {1'b1, 7'h0, 8'(count), 8'(head[EW-1:WIDTH]), 8'(head[WIDTH-1:0])} : 32'h0;
          2'd2: readdata_q <= {30'h0, ctrl_irq_en, ctrl_en};
          default: readdata_q <= {16'h0, 8'(count), 7'h0, overflow};
        endcase
      end
      irq <= ctrl_irq_en && (count != '0);
    end
  end

endmodule

// File: tb/tb_keys_poll_ctrl.sv
// tb/tb_keys_poll_ctrl.sv - scoreboard bench for keys_poll_ctrl
module tb_keys_poll_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       irq;
  logic [7:0] key_in = 8'h00;

  keys_poll_ctrl_if pio();
  keys_poll_ctrl_if host();

  keys_poll_ctrl #(
    .WIDTH(8), .POLL_DIV(8), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m(pio), .s(host), .irq(irq)
  );

  always #5 clk = ~clk;

  // PIO model: readdata valid only in the cycle after the read strobe
  always @(posedge clk) pio.readdata <= pio.read ? {24'h0, key_in} : 32'hDEADBEEF;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
  endtask

  initial begin : monitor
    logic pend;
    exp_t e;
    forever begin
      @(posedge clk);
      pend = host.read;
      @(negedge clk);
      if (pend && reset_n) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_read: got 0x%08h, expected no read response", host.readdata);
        end else begin
          e = exp_q.pop_front();
          check(e.name, host.readdata, e.val);
        end
      end
    end
  end

  task automatic host_read(input logic [1:0] a, input logic [31:0] e, input string nm);
    exp_t x;
    @(negedge clk);
    host.address = a;
    host.read = 1'b1;
    x.name = nm;
    x.val = e;
    exp_q.push_back(x);
    @(negedge clk);
    host.read = 1'b0;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    host.address = a;
    host.writedata = d;
    host.write = 1'b1;
    @(negedge clk);
    host.write = 1'b0;
  endtask

  task automatic wait_read();
    int t;
    t = 0;
    @(negedge clk);
    while (pio.read !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (pio.read !== 1'b1) begin
      n_total++;
      $display("FAIL poll_timeout: got no m_read in 40 cycles, expected one");
    end
  endtask

  task automatic polls(input int n);
    repeat (n) wait_read();
    repeat (4) @(negedge clk);
  endtask

  task automatic enable_poll(input logic [31:0] c, input string nm);
    int k;
    @(negedge clk);
    host.address = 2'd2;
    host.writedata = c;
    host.write = 1'b1;
    @(posedge clk);
    #1 host.write = 1'b0;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1 k++;
      if (pio.read === 1'b1) break;
    end
    check(nm, k, 8);
    check({nm, "_addr"}, 32'(pio.address), 0);
    @(posedge clk);
    #1 check({nm, "_width"}, 32'(pio.read), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int seen;
    logic [7:0] vals1 [5] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] vals2 [4] = '{8'h07, 8'h08, 8'h09, 8'h0A};

    host.address = 2'd0;
    host.read = 1'b0;
    host.write = 1'b0;
    host.writedata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_m_read", 32'(pio.read), 0);
    check("reset_m_address", 32'(pio.address), 0);
    check("reset_s_readdata", host.readdata, 0);
    check("reset_irq", 32'(irq), 0);
    reset_n = 1'b1;
    host_read(2'd0, 32'h0, "reset_state");
    host_read(2'd2, 32'h0, "reset_ctrl");
    host_read(2'd3, 32'h0, "reset_status");

    enable_poll(32'h1, "first_poll_latency");
    k = 1;
    while (k < 20) begin
      @(posedge clk);
      #1 k++;
      if (pio.read === 1'b1) break;
    end
    check("poll_period", k, 8);
    repeat (3) @(negedge clk);

    key_in = 8'h05;
    polls(2);
    host_read(2'd0, 32'h0, "state_before_accept");
    polls(1);
    host_read(2'd0, 32'h05, "state_05");
    host_read(2'd1, 32'h8001_0505, "event_05");
    host_read(2'd1, 32'h0, "event_empty");

    polls(1);
    key_in = 8'h00;
    polls(3);
    host_read(2'd1, 32'h8001_0500, "event_back_to_0");

    polls(1);
    for (int i = 0; i < 6; i++) begin
      key_in = (i % 2 == 0) ? 8'h01 : 8'h00;
      polls(1);
    end
    host_read(2'd0, 32'h0, "bounce_state");
    host_read(2'd3, 32'h0, "bounce_no_event");
    polls(1);
    key_in = 8'h01;
    polls(3);
    host_read(2'd0, 32'h01, "steady_state_01");
    host_read(2'd1, 32'h8001_0101, "event_01");
    host_read(2'd1, 32'h0, "event_01_single");

    host_write(2'd2, 32'h3);
    polls(1);
    foreach (vals1[i]) begin
      key_in = vals1[i];
      polls(3);
    end
    check("irq_high", 32'(irq), 1);
    host_read(2'd3, 32'h0000_0401, "status_full_ovf");
    host_read(2'd0, 32'h06, "state_06");
    host_write(2'd3, 32'h1);
    host_read(2'd3, 32'h0000_0400, "status_ovf_cleared");
    host_read(2'd1, 32'h8004_0302, "pop_1");
    host_read(2'd1, 32'h8003_0103, "pop_2");
    host_read(2'd1, 32'h8002_0704, "pop_3");
    host_read(2'd1, 32'h8001_0105, "pop_4");
    check("irq_hold_after_last_pop", 32'(irq), 1);
    @(negedge clk);
    check("irq_fall", 32'(irq), 0);
    host_read(2'd3, 32'h0, "status_empty");

    polls(1);
    foreach (vals2[i]) begin
      key_in = vals2[i];
      polls(3);
    end
    key_in = 8'h0B;
    polls(2);
    wait_read();
    @(negedge clk);
    host_read(2'd1, 32'h8004_0107, "pop_on_push");
    host_read(2'd3, 32'h0000_0400, "pop_push_full_status");
    host_read(2'd1, 32'h8004_0F08, "drain_1");
    host_read(2'd1, 32'h8003_0109, "drain_2");
    host_read(2'd1, 32'h8002_030A, "drain_3");
    host_read(2'd1, 32'h8001_010B, "drain_4");

    polls(1);
    key_in = 8'h0C;
    polls(2);
    wait_read();
    host.address = 2'd2;
    host.writedata = 32'h2;
    host.write = 1'b1;
    @(negedge clk);
    host.write = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (pio.read === 1'b1) seen++;
    end
    check("no_poll_after_disable", seen, 0);
    host_read(2'd1, 32'h8001_070C, "inflight_push");
    host_read(2'd0, 32'h0C, "state_0c");
    host_read(2'd2, 32'h2, "ctrl_disabled");

    enable_poll(32'h3, "reenable_latency");
    repeat (3) @(negedge clk);
    key_in = 8'h0D;
    polls(3);
    check("irq_before_reset", 32'(irq), 1);
    host_read(2'd0, 32'h0D, "state_0d");
    wait_read();
    reset_n = 1'b0;
    #1;
    check("async_reset_m_read", 32'(pio.read), 0);
    check("async_reset_irq", 32'(irq), 0);
    check("async_reset_readdata", host.readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    host_read(2'd3, 32'h0, "fifo_empty_after_reset");
    host_read(2'd0, 32'h0, "state_after_reset");
    host_read(2'd2, 32'h0, "ctrl_after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
